// File: rtl/xc_malu_pmul_seq.sv
// xc_malu_pmul_seq: multi-cycle sequencer and lane-segmented packed adder for
// packed multiply (pmul / pmulh). Owns acc, arg_0 and count; the step logic
// downstream computes the next values and says when the lane width is reached.
//
// Optional build macro: XC_MALU_PMUL_SEQ_FAST_DONE_EN
//   defined   : no DONE state, op_ready is raised combinationally in the
//               finishing cycle (latency W+1; a bad op_pw answers in IDLE).
//   undefined : result is registered and presented from a DONE cycle (W+2).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for op_valid; latches operands on a legal op_pw
// RUN   | one step per cycle until st_ready, abort when op_valid drops
// DONE  | op_ready pulse with the registered result (default build)

module xc_malu_pmul_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_high,
    input  logic        op_carryless,
    input  logic [3:0]  op_pw,
    input  logic [31:0] op_rs1,
    input  logic [31:0] op_rs2,
    output logic        op_ready,
    output logic [31:0] op_rd,
    output logic [5:0]  st_count,
    output logic [63:0] st_acc,
    output logic [31:0] st_arg_0,
    output logic [3:0]  st_pw,
    output logic [31:0] st_rs1,
    output logic        st_carryless,
    input  logic [31:0] padd_lhs,
    input  logic [31:0] padd_rhs,
    input  logic        padd_sub,
    input  logic        padd_cen,
    output logic [31:0] padd_result,
    output logic [31:0] padd_cout,
    input  logic [63:0] st_n_acc,
    input  logic [31:0] st_n_arg_0,
    input  logic [63:0] st_result,
    input  logic        st_ready
);

`ifdef XC_MALU_PMUL_SEQ_FAST_DONE_EN
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t      state_q;
    state_t      state_d;

    logic [63:0] acc_q;
    logic [31:0] arg_0_q;
    logic [5:0]  count_q;
    logic [31:0] rs1_q;
    logic [3:0]  pw_q;
    logic        carryless_q;
    logic        high_q;
    logic [31:0] rd_q;

    logic        pw_ok;
    logic        start;
    logic        step;
    logic        rd_we;
    logic [31:0] rd_d;
    logic [31:0] res_sel;

    logic [31:0] lane_start;
    logic [31:0] rhs_x;
    logic        carry;
    logic        cin;

    assign st_count     = count_q;
    assign st_acc       = acc_q;
    assign st_arg_0     = arg_0_q;
    assign st_pw        = pw_q;
    assign st_rs1       = rs1_q;
    assign st_carryless = carryless_q;

    // legal lane width: exactly one of the four pw bits set
    assign pw_ok   = (op_pw != 4'b0000) && ((op_pw & (op_pw - 4'd1)) == 4'b0000);
    assign res_sel = high_q ? st_result[63:32] : st_result[31:0];

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        step     = 1'b0;
        rd_we    = 1'b0;
        rd_d     = 32'h0;
        op_ready = 1'b0;
        op_rd    = rd_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    if (pw_ok) begin
                        start   = 1'b1;
                        state_d = RUN;
                    end else begin
                        rd_we = 1'b1;
                        rd_d  = 32'h0;
`ifdef XC_MALU_PMUL_SEQ_FAST_DONE_EN
                        op_ready = 1'b1;
                        op_rd    = 32'h0;
`else
                        state_d  = DONE;
`endif
                    end
                end
            end
            RUN: begin
                if (!op_valid) begin
                    state_d = IDLE;
                end else if (st_ready) begin
                    rd_we = 1'b1;
                    rd_d  = res_sel;
`ifdef XC_MALU_PMUL_SEQ_FAST_DONE_EN
                    op_ready = 1'b1;
                    op_rd    = res_sel;
                    state_d  = IDLE;
`else
                    state_d  = DONE;
`endif
                end else begin
                    step = 1'b1;
                end
            end
`ifdef XC_MALU_PMUL_SEQ_FAST_DONE_EN
`else
            DONE: begin
                op_ready = 1'b1;
                state_d  = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // operand latches, iteration state and result register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= 64'h0;
            arg_0_q     <= 32'h0;
            count_q     <= 6'd0;
            rs1_q       <= 32'h0;
            pw_q        <= 4'b0000;
            carryless_q <= 1'b0;
            high_q      <= 1'b0;
            rd_q        <= 32'h0;
        end else begin
            if (start) begin
                rs1_q       <= op_rs1;
                pw_q        <= op_pw;
                carryless_q <= op_carryless;
                high_q      <= op_high;
                acc_q       <= 64'h0;
                arg_0_q     <= op_rs2;
                count_q     <= 6'd0;
            end else if (step) begin
                acc_q   <= st_n_acc;
                arg_0_q <= st_n_arg_0;
                count_q <= count_q + 6'd1;
            end
            if (rd_we) begin
                rd_q <= rd_d;
            end
        end
    end

    // bit positions that start a lane and so take padd_sub as carry-in;
    // an unset pw (only seen straight after reset) behaves as one 32-bit lane
    always_comb begin
        case (pw_q)
            4'b0001: lane_start = 32'h5555_5555;
            4'b0010: lane_start = 32'h1111_1111;
            4'b0100: lane_start = 32'h0101_0101;
            4'b1000: lane_start = 32'h0001_0001;
            default: lane_start = 32'h0000_0001;
        endcase
    end

    // lane-segmented ripple adder; carry-less mode degenerates to XOR
    always_comb begin
        padd_result = 32'h0;
        padd_cout   = 32'h0;
        carry       = 1'b0;
        cin         = 1'b0;
        rhs_x       = padd_rhs ^ {32{padd_sub}};
        for (int i = 0; i < 32; i++) begin
            cin            = lane_start[i] ? padd_sub : carry;
            padd_result[i] = padd_lhs[i] ^ rhs_x[i] ^ cin;
            carry          = (padd_lhs[i] & rhs_x[i]) | (cin & (padd_lhs[i] ^ rhs_x[i]));
            padd_cout[i]   = carry;
        end
        if (!padd_cen) begin
            padd_result = padd_lhs ^ padd_rhs;
            padd_cout   = 32'h0;
        end
    end

endmodule

// File: tb/tb_xc_malu_pmul_seq.sv
// Bench for xc_malu_pmul_seq. The bench also plays the downstream step logic
// (shift-and-add per lane using the DUT's packed adder) and checks products
// against a plain-arithmetic per-lane multiply model.

module tb_xc_malu_pmul_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_high = 1'b0;
    logic        op_carryless = 1'b0;
    logic [3:0]  op_pw = 4'b0000;
    logic [31:0] op_rs1 = 32'h0;
    logic [31:0] op_rs2 = 32'h0;
    logic        op_ready;
    logic [31:0] op_rd;
    logic [5:0]  st_count;
    logic [63:0] st_acc;
    logic [31:0] st_arg_0;
    logic [3:0]  st_pw;
    logic [31:0] st_rs1;
    logic        st_carryless;
    logic [31:0] padd_lhs;
    logic [31:0] padd_rhs;
    logic        padd_sub;
    logic        padd_cen;
    logic [31:0] padd_result;
    logic [31:0] padd_cout;
    logic [63:0] st_n_acc;
    logic [31:0] st_n_arg_0;
    logic [63:0] st_result;
    logic        st_ready;

    logic        direct = 1'b0;
    logic [31:0] d_lhs = 32'h0;
    logic [31:0] d_rhs = 32'h0;
    logic        d_sub = 1'b0;
    logic        d_cen = 1'b0;

    int checks = 0;
    int errors = 0;

    xc_malu_pmul_seq dut (
        .clock(clock), .reset(reset),
        .op_valid(op_valid), .op_high(op_high), .op_carryless(op_carryless),
        .op_pw(op_pw), .op_rs1(op_rs1), .op_rs2(op_rs2),
        .op_ready(op_ready), .op_rd(op_rd),
        .st_count(st_count), .st_acc(st_acc), .st_arg_0(st_arg_0),
        .st_pw(st_pw), .st_rs1(st_rs1), .st_carryless(st_carryless),
        .padd_lhs(padd_lhs), .padd_rhs(padd_rhs), .padd_sub(padd_sub), .padd_cen(padd_cen),
        .padd_result(padd_result), .padd_cout(padd_cout),
        .st_n_acc(st_n_acc), .st_n_arg_0(st_n_arg_0),
        .st_result(st_result), .st_ready(st_ready)
    );

    always #5 clock = ~clock;

    function automatic int lane_w(input logic [3:0] pw);
        case (pw)
            4'b0001: return 2;
            4'b0010: return 4;
            4'b0100: return 8;
            4'b1000: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic bit is_onehot(input logic [3:0] pw);
        return (pw == 4'b0001) || (pw == 4'b0010) || (pw == 4'b0100) || (pw == 4'b1000);
    endfunction

    function automatic int exp_lat(input logic [3:0] pw);
`ifdef XC_MALU_PMUL_SEQ_FAST_DONE_EN
        return is_onehot(pw) ? lane_w(pw) + 1 : 0;
`else
        return is_onehot(pw) ? lane_w(pw) + 2 : 1;
`endif
    endfunction

    // per-lane product, integer or GF(2), selecting the low or high half
    function automatic logic [31:0] ref_mul(input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [3:0] pw, input logic high, input logic cl);
        longint unsigned m, a, b, p, res;
        int w;
        if (!is_onehot(pw)) return 32'h0;
        w   = lane_w(pw);
        m   = (64'd1 << w) - 64'd1;
        res = 0;
        for (int l = 0; l < 32 / w; l++) begin
            a = (longint'(rs1) >> (l * w)) & m;
            b = (longint'(rs2) >> (l * w)) & m;
            if (cl) begin
                p = 0;
                for (int j = 0; j < w; j++) if (b[j]) p = p ^ (a << j);
            end else begin
                p = a * b;
            end
            res = res | ((high ? ((p >> w) & m) : (p & m)) << (l * w));
        end
        return res[31:0];
    endfunction

    // {cout, result} of the lane-segmented add
    function automatic logic [63:0] ref_padd(input logic [31:0] lhs, input logic [31:0] rhs,
                                             input logic sub, input logic cen, input int w);
        longint unsigned m, a, b, s, mj, res, co;
        logic [31:0] rx;
        if (!cen) return {32'h0, lhs ^ rhs};
        rx  = rhs ^ {32{sub}};
        m   = (64'd1 << w) - 64'd1;
        res = 0;
        co  = 0;
        for (int l = 0; l < 32 / w; l++) begin
            a   = (longint'(lhs) >> (l * w)) & m;
            b   = (longint'(rx) >> (l * w)) & m;
            s   = a + b + longint'(sub);
            res = res | ((s & m) << (l * w));
            for (int j = 0; j < w; j++) begin
                mj = (64'd1 << (j + 1)) - 64'd1;
                s  = (a & mj) + (b & mj) + longint'(sub);
                co = co | (((s >> (j + 1)) & 64'd1) << (l * w + j));
            end
        end
        return {co[31:0], res[31:0]};
    endfunction

    // step logic: padd operands from current state
    always_comb begin
        padd_lhs = st_acc[63:32];
        padd_rhs = 32'h0;
        padd_sub = 1'b0;
        padd_cen = !st_carryless;
        for (int i = 0; i < 32; i++) begin
            padd_rhs[i] = st_rs1[i] & st_arg_0[i - (i % lane_w(st_pw))];
        end
        if (direct) begin
            padd_lhs = d_lhs;
            padd_rhs = d_rhs;
            padd_sub = d_sub;
            padd_cen = d_cen;
        end
    end

    // step logic: shift {hi, lo} right per lane after the conditional add
    logic [31:0] res_sh, lo_sh, arg_sh;
    assign res_sh = padd_result >> 1;
    assign lo_sh  = st_acc[31:0] >> 1;
    assign arg_sh = st_arg_0 >> 1;
    always_comb begin
        st_n_acc   = 64'h0;
        st_n_arg_0 = 32'h0;
        for (int i = 0; i < 32; i++) begin
            if ((i % lane_w(st_pw)) == lane_w(st_pw) - 1) begin
                st_n_acc[32 + i] = padd_cout[i];
                st_n_acc[i]      = padd_result[i - (i % lane_w(st_pw))];
                st_n_arg_0[i]    = 1'b0;
            end else begin
                st_n_acc[32 + i] = res_sh[i];
                st_n_acc[i]      = lo_sh[i];
                st_n_arg_0[i]    = arg_sh[i];
            end
        end
    end

    assign st_result = st_acc;
    assign st_ready  = (int'(st_count) == lane_w(st_pw));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] pw,
                          input logic high, input logic cl,
                          output logic [31:0] rd, output int lat);
        @(negedge clock);
        op_rs1 = rs1; op_rs2 = rs2; op_pw = pw; op_high = high; op_carryless = cl;
        op_valid = 1'b1;
        #1;
        lat = 0;
        while (!op_ready && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        rd = op_rd;
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL op_ready timeout: got no pulse within %0d cycles", lat);
        end
        @(posedge clock);
        #1;
        op_valid = 1'b0;
    endtask

    // run one op and check result, latency, pulse width and result hold
    task automatic do_op(input string name, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] pw, input logic high, input logic cl,
                         input logic [31:0] exp_rd);
        logic [31:0] rd;
        int lat;
        run_op(rs1, rs2, pw, high, cl, rd, lat);
        chk({name, " rd"}, 64'(rd), 64'(exp_rd));
        chk({name, " latency"}, 64'(lat), 64'(exp_lat(pw)));
        @(negedge clock);
        chk({name, " single pulse"}, 64'(op_ready), 64'd0);
        chk({name, " rd hold"}, 64'(op_rd), 64'(exp_rd));
    endtask

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  pw;
        logic        high;
        logic        cl;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] rs1, rs2, rd_exp;
        logic [3:0]  pw;
        logic        high, cl;
        logic [63:0] pref;
        int          guard;

        tbl[0] = '{32'h0003_0005, 32'h0007_0009, 4'b1000, 1'b0, 1'b0, 32'h0015_002D};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0, 32'h0001_0001};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0, 32'hFFFE_FFFE};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 1'b0, 1'b0, 32'h5555_5555};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 1'b1, 1'b0, 32'hAAAA_AAAA};
        tbl[5] = '{32'h0303_0303, 32'h0303_0303, 4'b0100, 1'b0, 1'b1, 32'h0505_0505};
        tbl[6] = '{32'h0303_0303, 32'h0303_0303, 4'b0100, 1'b0, 1'b0, 32'h0909_0909};
        tbl[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 4'b0110, 1'b0, 1'b0, 32'h0000_0000};
        tbl[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};

        // reset state
        #1;
        chk("reset op_ready", 64'(op_ready), 64'd0);
        chk("reset op_rd", 64'(op_rd), 64'd0);
        chk("reset acc", st_acc, 64'd0);
        chk("reset count", 64'(st_count), 64'd0);
        chk("reset arg_0", 64'(st_arg_0), 64'd0);
        chk("reset pw", 64'(st_pw), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // directed vectors
        for (int n = 0; n < 9; n++) begin
            do_op($sformatf("vec%0d", n), tbl[n].rs1, tbl[n].rs2, tbl[n].pw,
                  tbl[n].high, tbl[n].cl, tbl[n].exp_rd);
        end

        // packed adder driven directly, once per lane width
        for (int k = 0; k < 4; k++) begin
            pw = 4'b0001 << k;
            rs1 = $urandom;
            rs2 = $urandom;
            do_op("pw setup", rs1, rs2, pw, 1'b0, 1'b0, ref_mul(rs1, rs2, pw, 1'b0, 1'b0));
            chk("latched pw", 64'(st_pw), 64'(pw));
            chk("latched rs1", 64'(st_rs1), 64'(rs1));
            for (int t = 0; t < 8; t++) begin
                @(negedge clock);
                direct = 1'b1;
                d_lhs = (t == 0) ? 32'hFFFF_FFFF : $urandom;
                d_rhs = (t == 0) ? 32'h0000_0001 : $urandom;
                d_sub = (t % 3 == 1);
                d_cen = (t != 7);
                #1;
                pref = ref_padd(d_lhs, d_rhs, d_sub, d_cen, lane_w(pw));
                chk($sformatf("padd result w%0d", lane_w(pw)), 64'(padd_result), 64'(pref[31:0]));
                chk($sformatf("padd cout w%0d", lane_w(pw)), 64'(padd_cout), 64'(pref[63:32]));
            end
            direct = 1'b0;
        end

        // randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            pw   = (n % 8 == 7) ? 4'b1010 : (4'b0001 << $urandom_range(0, 3));
            high = 1'($urandom % 2);
            cl   = 1'($urandom % 2);
            rs1  = $urandom;
            rs2  = $urandom;
            rd_exp = ref_mul(rs1, rs2, pw, high, cl);
            do_op($sformatf("rand%0d", n), rs1, rs2, pw, high, cl, rd_exp);
            if (is_onehot(pw)) chk("latched carryless", 64'(st_carryless), 64'(cl));
        end

        // abort by dropping op_valid at count 5
        @(negedge clock);
        op_rs1 = tbl[0].rs1; op_rs2 = tbl[0].rs2; op_pw = 4'b1000;
        op_high = 1'b0; op_carryless = 1'b0; op_valid = 1'b1;
        guard = 0;
        while (st_count != 6'd5 && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        chk("abort reached count 5", 64'(st_count), 64'd5);
        op_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            chk("abort no op_ready", 64'(op_ready), 64'd0);
        end
        chk("abort count holds", 64'(st_count), 64'd5);

        // reset in the middle of a run
        @(negedge clock);
        op_valid = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        op_valid = 1'b0;
        chk("midrun reset op_ready", 64'(op_ready), 64'd0);
        chk("midrun reset acc", st_acc, 64'd0);
        chk("midrun reset count", 64'(st_count), 64'd0);
        chk("midrun reset arg_0", 64'(st_arg_0), 64'd0);
        @(negedge clock);
        chk("midrun reset idle", 64'(op_ready), 64'd0);
        reset = 1'b0;
        do_op("after reset", tbl[0].rs1, tbl[0].rs2, tbl[0].pw, 1'b0, 1'b0, tbl[0].exp_rd);
        do_op("after reset h", 32'h00FF_0010, 32'h0101_0100, 4'b1000, 1'b1, 1'b0,
              ref_mul(32'h00FF_0010, 32'h0101_0100, 4'b1000, 1'b1, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
